// File: rtl/vector_mac_engine_if.sv
// Beat-input and result-output handshake bundle for vector_mac_engine.
// master = producer/consumer side, slave = engine side.
interface vector_mac_engine_if #(
    parameter int LANES          = 8,
    parameter int FEATURE_WIDTH  = 5,
    parameter int DOT_PROD_WIDTH = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [FEATURE_WIDTH-1:0]  in_feature [0:LANES-1];
    logic [FEATURE_WIDTH-1:0]  in_weight  [0:LANES-1];
    logic [LANES-1:0]          in_lane_mask;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [DOT_PROD_WIDTH-1:0] dot_product;
    logic                      overflow;
    logic                      length_err;

    modport master (
        output in_valid, in_feature, in_weight, in_lane_mask, in_last, out_ready,
        input  in_ready, out_valid, dot_product, overflow, length_err
    );

    modport slave (
        input  in_valid, in_feature, in_weight, in_lane_mask, in_last, out_ready,
        output in_ready, out_valid, dot_product, overflow, length_err
    );
endinterface

// File: rtl/vector_mac_engine.sv
// Lane-parallel dot-product engine: masked lane multiply, registered lane sum, accumulate per vector.
// Optional macro VMAC_SATURATE_EN clamps the accumulator at all-ones on overflow instead of wrapping.
module vector_mac_engine #(
    parameter int FEATURE_COLS   = 96,
    parameter int LANES          = 8,
    parameter int FEATURE_WIDTH  = 5,
    parameter int DOT_PROD_WIDTH = 16
) (
    input logic           clk,
    input logic           reset,
    vector_mac_engine_if.slave bus
);
    localparam int BEATS = (FEATURE_COLS + LANES - 1) / LANES;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam int SUM_W = 2 * FEATURE_WIDTH + $clog2(LANES);

    typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    drain_cnt;
    logic [CNT_W-1:0]        beat_cnt;
    logic [CNT_W-1:0]        beat_cur;
    logic                    accept;
    logic                    end_beat;
    logic                    len_bad;
    logic                    clear;
    logic [SUM_W-1:0]        lane_sum;
    logic [SUM_W-1:0]        s1_sum;
    logic                    s1_valid;
    logic [DOT_PROD_WIDTH-1:0] acc;
    logic [DOT_PROD_WIDTH:0] add_res;
    logic                    ovf;
    logic                    len_err;

    assign bus.in_ready  = (state == ACCUM) && !reset;
    assign bus.out_valid = (state == DONE) && !reset;
    assign accept        = bus.in_valid && (state == ACCUM) && !reset;

    assign beat_cur = beat_cnt + CNT_W'(1);
    assign end_beat = bus.in_last || (beat_cur == CNT_W'(BEATS));
    assign len_bad  = bus.in_last ? (beat_cur != CNT_W'(BEATS)) : (beat_cur == CNT_W'(BEATS));

    always_comb begin
        lane_sum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (bus.in_lane_mask[i])
                lane_sum = lane_sum + SUM_W'(bus.in_feature[i]) * SUM_W'(bus.in_weight[i]);
        end
    end

    assign add_res = {1'b0, acc} + (DOT_PROD_WIDTH + 1)'(s1_sum);

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        case (state)
            ACCUM: if (accept && end_beat) state_next = DRAIN;
            DRAIN: if (drain_cnt) state_next = DONE;
            DONE: begin
                if (bus.out_ready) begin
                    state_next = ACCUM;
                    clear      = 1'b1;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACCUM;
            drain_cnt <= 1'b0;
            beat_cnt  <= '0;
            s1_valid  <= 1'b0;
            s1_sum    <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            s1_valid  <= accept;
            if (accept)
                s1_sum <= lane_sum;
            // DRAIN covers the stage-1 and stage-2 edges, so clear never meets a pending add
            if (clear) begin
                beat_cnt <= '0;
                acc      <= '0;
                ovf      <= 1'b0;
                len_err  <= 1'b0;
            end else begin
                if (accept) begin
                    beat_cnt <= beat_cur;
                    if (len_bad)
                        len_err <= 1'b1;
                end
                if (s1_valid) begin
                    if (add_res[DOT_PROD_WIDTH])
                        ovf <= 1'b1;
`ifdef VMAC_SATURATE_EN
                    if (ovf || add_res[DOT_PROD_WIDTH])
                        acc <= '1;
                    else
                        acc <= add_res[DOT_PROD_WIDTH-1:0];
`else
                    acc <= add_res[DOT_PROD_WIDTH-1:0];
`endif
                end
            end
        end
    end

    assign bus.dot_product = acc;
    assign bus.overflow    = ovf;
    assign bus.length_err  = len_err;
endmodule

// File: tb/tb_vector_mac_engine.sv
// Self-checking bench for vector_mac_engine: a 16-bit and a 12-bit instance share one stimulus
// stream and are compared against a whole-vector arithmetic reference model.
module tb_vector_mac_engine;
    localparam int FEATURE_COLS  = 8;
    localparam int LANES         = 4;
    localparam int FEATURE_WIDTH = 5;
    localparam int WIDE          = 16;
    localparam int NARROW        = 12;
    localparam int BEATS         = (FEATURE_COLS + LANES - 1) / LANES;
    localparam int TIMEOUT       = 50;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vector_mac_engine_if #(.LANES(LANES), .FEATURE_WIDTH(FEATURE_WIDTH), .DOT_PROD_WIDTH(WIDE))   bus_w ();
    vector_mac_engine_if #(.LANES(LANES), .FEATURE_WIDTH(FEATURE_WIDTH), .DOT_PROD_WIDTH(NARROW)) bus_n ();

    assign bus_n.in_valid     = bus_w.in_valid;
    assign bus_n.in_feature   = bus_w.in_feature;
    assign bus_n.in_weight    = bus_w.in_weight;
    assign bus_n.in_lane_mask = bus_w.in_lane_mask;
    assign bus_n.in_last      = bus_w.in_last;
    assign bus_n.out_ready    = bus_w.out_ready;

    vector_mac_engine #(.FEATURE_COLS(FEATURE_COLS), .LANES(LANES),
                        .FEATURE_WIDTH(FEATURE_WIDTH), .DOT_PROD_WIDTH(WIDE))
        dut_w (.clk(clk), .reset(reset), .bus(bus_w));

    vector_mac_engine #(.FEATURE_COLS(FEATURE_COLS), .LANES(LANES),
                        .FEATURE_WIDTH(FEATURE_WIDTH), .DOT_PROD_WIDTH(NARROW))
        dut_n (.clk(clk), .reset(reset), .bus(bus_n));

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    // Current vector under test
    logic [FEATURE_WIDTH-1:0] vf [0:BEATS-1][0:LANES-1];
    logic [FEATURE_WIDTH-1:0] vw [0:BEATS-1][0:LANES-1];
    logic [LANES-1:0]         vm [0:BEATS-1];
    int unsigned              vnb;
    bit                       vlast;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned true_sum();
        int unsigned s = 0;
        for (int b = 0; b < int'(vnb); b++)
            for (int l = 0; l < LANES; l++)
                if (vm[b][l]) s += int'(vf[b][l]) * int'(vw[b][l]);
        return s;
    endfunction

    function automatic int unsigned fit(input int unsigned s, input int unsigned w);
        int unsigned maxv = (32'd1 << w) - 1;
`ifdef VMAC_SATURATE_EN
        return (s > maxv) ? maxv : s;
`else
        return s & maxv;
`endif
    endfunction

    task automatic fill(input int unsigned f, input int unsigned w, input int unsigned nb, input bit last);
        for (int b = 0; b < BEATS; b++) begin
            for (int l = 0; l < LANES; l++) begin
                vf[b][l] = FEATURE_WIDTH'(f);
                vw[b][l] = FEATURE_WIDTH'(w);
            end
            vm[b] = '1;
        end
        vnb   = nb;
        vlast = last;
    endtask

    task automatic drive_beat(input int unsigned b, input int unsigned gap);
        int unsigned t = 0;
        repeat (gap) @(negedge clk);
        bus_w.in_valid = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            bus_w.in_feature[l] = vf[b][l];
            bus_w.in_weight[l]  = vw[b][l];
        end
        bus_w.in_lane_mask = vm[b];
        bus_w.in_last      = (b == vnb - 1) && vlast;
        while (!bus_w.in_ready && t < TIMEOUT) begin
            @(negedge clk);
            t++;
        end
        if (!bus_w.in_ready) check_eq("in_ready_wait", 32'(bus_w.in_ready), 1);
        @(negedge clk);
        bus_w.in_valid = 1'b0;
        bus_w.in_last  = 1'b0;
    endtask

    task automatic run_vector(input int unsigned gap, input int unsigned hold, input string name);
        int unsigned ts    = true_sum();
        int unsigned exp_w = fit(ts, WIDE);
        int unsigned exp_n = fit(ts, NARROW);
        bit          exp_l = !(vnb == BEATS && vlast);
        int unsigned t     = 0;
        for (int unsigned b = 0; b < vnb; b++) drive_beat(b, (b == 0) ? 0 : gap);
        check_eq({name, " valid_edge_n"}, 32'(bus_w.out_valid), 0);
        @(negedge clk);
        check_eq({name, " valid_edge_n1"}, 32'(bus_w.out_valid), 0);
        @(negedge clk);
        check_eq({name, " valid_edge_n2"}, 32'(bus_w.out_valid), 1);
        while (!bus_w.out_valid && t < TIMEOUT) begin
            @(negedge clk);
            t++;
        end
        bus_w.in_valid = (hold != 0);
        repeat (hold) begin
            for (int l = 0; l < LANES; l++) begin
                bus_w.in_feature[l] = FEATURE_WIDTH'($urandom_range(31, 0));
                bus_w.in_weight[l]  = FEATURE_WIDTH'($urandom_range(31, 0));
            end
            bus_w.in_lane_mask = LANES'($urandom);
            bus_w.in_last      = 1'($urandom);
            check_eq({name, " hold_in_ready"}, 32'(bus_w.in_ready), 0);
            check_eq({name, " hold_valid"}, 32'(bus_w.out_valid), 1);
            check_eq({name, " hold_dot"}, 32'(bus_w.dot_product), exp_w);
            @(negedge clk);
        end
        bus_w.in_valid = 1'b0;
        bus_w.in_last  = 1'b0;
        check_eq({name, " in_ready_done"}, 32'(bus_w.in_ready), 0);
        check_eq({name, " dot_w"}, 32'(bus_w.dot_product), exp_w);
        check_eq({name, " dot_n"}, 32'(bus_n.dot_product), exp_n);
        check_eq({name, " ovf_w"}, 32'(bus_w.overflow), 32'(ts > 32'hFFFF));
        check_eq({name, " ovf_n"}, 32'(bus_n.overflow), 32'(ts > 32'hFFF));
        check_eq({name, " len_w"}, 32'(bus_w.length_err), 32'(exp_l));
        check_eq({name, " len_n"}, 32'(bus_n.length_err), 32'(exp_l));
        bus_w.out_ready = 1'b1;
        @(negedge clk);
        bus_w.out_ready = 1'b0;
        check_eq({name, " valid_after_take"}, 32'(bus_w.out_valid), 0);
        check_eq({name, " in_ready_after_take"}, 32'(bus_w.in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_w.in_valid     = 1'b0;
        bus_w.in_last      = 1'b0;
        bus_w.in_lane_mask = '0;
        bus_w.out_ready    = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            bus_w.in_feature[l] = '0;
            bus_w.in_weight[l]  = '0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset out_valid", 32'(bus_w.out_valid), 0);
        check_eq("reset in_ready", 32'(bus_w.in_ready), 0);
        check_eq("reset dot", 32'(bus_w.dot_product), 0);
        check_eq("reset overflow", 32'(bus_w.overflow), 0);
        check_eq("reset length_err", 32'(bus_w.length_err), 0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("in_ready after reset", 32'(bus_w.in_ready), 1);

        // All 31s, full length: 7688 wide, overflows the 12-bit instance
        fill(31, 31, BEATS, 1'b1);
        run_vector(0, 0, "all31");

        // 10 + 52 = 62 with a 3-cycle gap, then 10 cycles of output backpressure
        fill(0, 0, 2, 1'b1);
        for (int l = 0; l < LANES; l++) begin
            vf[0][l] = FEATURE_WIDTH'(l + 1);
            vw[0][l] = 5'd1;
            vf[1][l] = FEATURE_WIDTH'(l + 5);
            vw[1][l] = 5'd2;
        end
        run_vector(3, 10, "gap_hold");

        // Early in_last on beat 1, then a clean vector
        fill(2, 2, 1, 1'b1);
        run_vector(0, 0, "early_last");
        fill(3, 1, BEATS, 1'b1);
        run_vector(0, 0, "clean_next");

        // Full length without in_last
        fill(1, 3, BEATS, 1'b0);
        run_vector(1, 0, "missing_last");

        // Reset mid-vector discards the partial beat
        fill(1, 1, BEATS, 1'b1);
        drive_beat(0, 0);
        reset = 1'b1;
        #1;
        check_eq("in_ready in reset", 32'(bus_w.in_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_eq("no result after reset", 32'(bus_w.out_valid), 0);
        end
        run_vector(0, 0, "after_reset");

        for (int unsigned k = 0; k < 40; k++) begin
            bit hot = ($urandom_range(3, 0) == 0);
            for (int b = 0; b < BEATS; b++) begin
                for (int l = 0; l < LANES; l++) begin
                    vf[b][l] = hot ? 5'd31 : FEATURE_WIDTH'($urandom_range(31, 0));
                    vw[b][l] = hot ? 5'd31 : FEATURE_WIDTH'($urandom_range(31, 0));
                end
                vm[b] = ($urandom_range(1, 0) == 0) ? '1 : LANES'($urandom);
            end
            vnb   = $urandom_range(BEATS, 1);
            vlast = (vnb < BEATS) ? 1'b1 : ($urandom_range(3, 0) != 0);
            run_vector($urandom_range(2, 0), $urandom_range(3, 0), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
